// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared definitions for the FIR receive-side blocks: default sample width,
//   default source hold period and the tone analyzer state encoding.
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int DATA_W_DEF = 32;  // FIR o_data width
  localparam int HOLD_DEF   = 5;   // clocks per source sample

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // disabled, nothing tracked
    ST_SEEK = 2'd1,  // waiting for the first rising crossing
    ST_MEAS = 2'd2   // measuring between consecutive crossings
  } state_e;

endpackage : fir_pkg

// File: rtl/sample_strobe_gen.sv
// -----------------------------------------------------------------------------
// sample_strobe_gen
//   Divides the system clock down to the source sample rate. The counter runs
//   0..HOLD-1 while enabled and strobe is high in the cycle where it sits at
//   HOLD-1 (it wraps to 0 on that same edge).
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low reset
//   enable  in   run enable; low holds the counter at 0
//   strobe  out  one-clock pulse, once every HOLD clocks
// -----------------------------------------------------------------------------
module sample_strobe_gen #(
  parameter int HOLD = fir_pkg::HOLD_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic strobe
);

  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] scnt_q, scnt_d;

  assign strobe = enable && (scnt_q == CNT_LAST);

  always_comb begin
    // NOTE: next-state comes from a default-first always_comb so every path
    // assigns scnt_d and no latch can be inferred.
    scnt_d = '0;
    if (enable && (scnt_q != CNT_LAST)) begin
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!reset) scnt_q <= '0;
    else        scnt_q <= scnt_d;
  end

endmodule : sample_strobe_gen

// File: rtl/fir_tone_analyzer.sv
// -----------------------------------------------------------------------------
// fir_tone_analyzer
//   Receive-side monitor for the FIR output stream. Decimates i_data to one
//   sample per source hold period, detects rising zero crossings with
//   hysteresis and, per tone cycle, reports period (samples), peak and trough.
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable_buff  in   run enable; low = idle, clears lock/overflow
//   i_data       in   signed FIR output sample
//   o_period     out  samples between the last two rising crossings
//   o_peak       out  signed max over the last complete cycle
//   o_trough     out  signed min over the last complete cycle
//   o_valid      out  one-clock pulse when period/peak/trough update
//   o_lock       out  two consecutive equal non-zero periods
//   o_overflow   out  sticky: period counter saturated
// -----------------------------------------------------------------------------
module fir_tone_analyzer
  import fir_pkg::*;
#(
  parameter int                       DATA_W = DATA_W_DEF,
  parameter int                       HOLD   = HOLD_DEF,
  parameter int                       PER_W  = 8,
  parameter logic signed [DATA_W-1:0] HYST   = DATA_W'(256)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_buff,
  input  logic [DATA_W-1:0] i_data,
  output logic [PER_W-1:0]  o_period,
  output logic [DATA_W-1:0] o_peak,
  output logic [DATA_W-1:0] o_trough,
  output logic              o_valid,
  output logic              o_lock,
  output logic              o_overflow
);

  localparam logic [PER_W-1:0] PCNT_MAX = '1;

  logic strobe;

  sample_strobe_gen #(.HOLD(HOLD)) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .enable (enable_buff),
    .strobe (strobe)
  );

  state_e                    state_q, state_d;
  logic                      arm_q, arm_d;
  logic [PER_W-1:0]          pcnt_q, pcnt_d;
  logic signed [DATA_W-1:0]  acc_max_q, acc_max_d;
  logic signed [DATA_W-1:0]  acc_min_q, acc_min_d;
  logic [PER_W-1:0]          period_q, period_d;
  logic signed [DATA_W-1:0]  peak_q, peak_d;
  logic signed [DATA_W-1:0]  trough_q, trough_d;
  logic                      valid_q, valid_d;
  logic                      lock_q, lock_d;
  logic                      ovf_q, ovf_d;

  logic signed [DATA_W-1:0]  sample;
  logic                      crossing;

  assign sample   = $signed(i_data);
  // A sample of exactly zero while armed is a crossing.
  assign crossing = strobe && arm_q && (sample >= 0);

  always_comb begin
    state_d   = state_q;
    arm_d     = arm_q;
    pcnt_d    = pcnt_q;
    acc_max_d = acc_max_q;
    acc_min_d = acc_min_q;
    period_d  = period_q;
    peak_d    = peak_q;
    trough_d  = trough_q;
    valid_d   = 1'b0;
    lock_d    = lock_q;
    ovf_d     = ovf_q;

    // Hysteresis: only a deep negative excursion re-arms detection.
    if (crossing)                      arm_d = 1'b0;
    else if (strobe && sample < -HYST) arm_d = 1'b1;

    if (!enable_buff) begin
      // Disable wins over a coincident crossing; results are held.
      state_d = ST_IDLE;
      lock_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_SEEK;
        ST_SEEK: begin
          if (crossing) begin
            state_d   = ST_MEAS;
            pcnt_d    = PER_W'(1);
            acc_max_d = sample;
            acc_min_d = sample;
          end
        end
        ST_MEAS: begin
          if (crossing) begin
            period_d  = pcnt_q;
            peak_d    = acc_max_q;
            trough_d  = acc_min_q;
            valid_d   = 1'b1;
            lock_d    = (pcnt_q == period_q) && (pcnt_q != '0);
            // The crossing sample opens the next cycle.
            pcnt_d    = PER_W'(1);
            acc_max_d = sample;
            acc_min_d = sample;
          end else if (strobe) begin
            if (pcnt_q == PCNT_MAX) begin
              // Tone too slow to measure: drop it and look for a fresh crossing.
              ovf_d   = 1'b1;
              lock_d  = 1'b0;
              state_d = ST_SEEK;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
              if (sample > acc_max_q) acc_max_d = sample;
              if (sample < acc_min_q) acc_min_d = sample;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the accumulators are plain registers, not memories, so they are
    // reset along with everything else; a mid-cycle reset leaves nothing stale.
    if (!reset) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      pcnt_q    <= '0;
      acc_max_q <= '0;
      acc_min_q <= '0;
      period_q  <= '0;
      peak_q    <= '0;
      trough_q  <= '0;
      valid_q   <= 1'b0;
      lock_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      pcnt_q    <= pcnt_d;
      acc_max_q <= acc_max_d;
      acc_min_q <= acc_min_d;
      period_q  <= period_d;
      peak_q    <= peak_d;
      trough_q  <= trough_d;
      valid_q   <= valid_d;
      lock_q    <= lock_d;
      ovf_q     <= ovf_d;
    end
  end

  assign o_period   = period_q;
  assign o_peak     = peak_q;
  assign o_trough   = trough_q;
  assign o_valid    = valid_q;
  assign o_lock     = lock_q;
  assign o_overflow = ovf_q;

endmodule : fir_tone_analyzer
